note_sequencer: RTL and testbench
=================================

# note_sequencer

Keypad-driven step sequencer and note arbiter that sits between the keypad decoder and the note-index-to-phase-increment lookup feeding the shared phase accumulator. It records up to `STEPS_P` note indices from the keypad and plays them back at a fixed tempo. During playback it arbitrates the single oscillator note input, giving a held live key priority over the pattern. It outputs the 4-bit note index and a gate that downstream logic uses in place of the raw "key pressed" enable.

## Interface
- `STEPS_P`, 16: pattern depth in steps (power of two, ≤16).
- `TEMPO_DIV_P`, 12000: `clk_48kHz` cycles per step (4 steps/s).
- `GATE_DIV_P`, 9000: cycles the gate stays high at the start of each step; must satisfy 1 ≤ `GATE_DIV_P` ≤ `TEMPO_DIV_P`.

- `clk_48kHz`, in, 1: system/sample clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `mode_i`, in, 2: 00 LIVE, 01 REC, 10 PLAY, 11 treated as LIVE.
- `key_valid_i`, in, 1: one-cycle pulse when a new key is decoded.
- `key_code_i`, in, 4: decoded key index; valid with `key_valid_i`.
- `key_held_i`, in, 1: level, high while any key is pressed.
- `clear_i`, in, 1: one-cycle pulse that empties the pattern.
- `note_o`, out, 4: note index to the LUT.
- `gate_o`, out, 1: oscillator enable.
- `step_o`, out, 4: current playback step.
- `len_o`, out, 5: number of recorded steps, 0..`STEPS_P`.
- `full_o`, out, 1: `len_o == STEPS_P`.
- `step_tick_o`, out, 1: one-cycle pulse at the start of each played step.
- `state_o`, out, 2: 0 LIVE, 1 REC, 2 PLAY.

## Operation
- State storage:
  - `mem[STEPS_P]` × 4 bits, not reset.
  - `len` (5 b), `step` (4 b), tempo counter `cnt` (0..`TEMPO_DIV_P`-1).
  - `live_note`: last `key_code_i` captured on `key_valid_i`, in every state.
- The FSM follows `mode_i` every cycle; `state_o` changes on the next edge.
- LIVE:
  - `note_o` = `live_note`, `gate_o` = `key_held_i`, both registered.
  - `step_o` = 0, `cnt` held at 0.
- REC: outputs behave as in LIVE (monitoring). On `key_valid_i` with `len < STEPS_P`: `mem[len]` ← `key_code_i` and `len` increments. When full, key pulses are ignored for storage but still update `live_note`.
- PLAY entry (any other state → PLAY): `step` ← 0, `cnt` ← 0, `step_tick_o` = 1, `note_o` ← `mem[0]`, `gate_o` ← 1, all in the first PLAY cycle.
- PLAY steady state:
  - `cnt` increments each cycle and wraps at `TEMPO_DIV_P`-1.
  - On the wrap edge: `step` ← (`step`+1 == `len`) ? 0 : `step`+1; `note_o` ← `mem[new step]`; `step_tick_o` = 1; `gate_o` ← 1.
  - `gate_o` ← 0 on the edge where `cnt` becomes `GATE_DIV_P`.
- PLAY with `len` == 0: `gate_o` = 0, `note_o` holds, `step_o` = 0, `step_tick_o` = 0.
- Live override: in PLAY, when `key_held_i` = 1, `note_o` = `live_note` and `gate_o` = 1. The pattern keeps advancing internally (`step`, `cnt`, `step_tick_o` unaffected). Release returns to the pattern note and gate on the next edge.
- `clear_i` (any state):
  - `len` ← 0 and `step` ← 0.
  - In PLAY, `gate_o` drops on the next edge unless live override is active.
  - `clear_i` wins over a simultaneous `key_valid_i`; that key is not stored but does update `live_note`.
- Leaving PLAY: `gate_o` follows LIVE/REC rules from the next edge; `step` and `cnt` reset to 0.
- Reset values: state LIVE, `len` 0, `step` 0, `cnt` 0, `live_note` 0, `note_o` 0, `gate_o` 0, `step_o` 0, `step_tick_o` 0, `full_o` 0, `state_o` 0.

## Timing
- All outputs are registered, with 1-cycle latency from any input.
- Step period is exactly `TEMPO_DIV_P` cycles; the gate is high for exactly `GATE_DIV_P` cycles per step. When `GATE_DIV_P` == `TEMPO_DIV_P`, the gate stays continuously high across steps.
- `full_o` and `len_o` update on the same edge as the write.
- Reset mid-playback takes effect on the next edge; the gate is low one cycle after `rst_n` is sampled low.

## Test plan
Benches override `TEMPO_DIV_P`=8, `GATE_DIV_P`=6.
- Reset, then LIVE: pulse key 5 and hold → `note_o`=5, `gate_o`=1 one cycle later; release → `gate_o`=0 next cycle.
- REC: keys 1, 2, 3, then PLAY for 32 cycles → `note_o` sequence 1,2,3,1. `step_tick_o` fires every 8 cycles. `gate_o` is high 6 cycles and low 2 per step. `len_o`=3.
- REC: 17 key pulses → `len_o`=16, `full_o`=1; the 17th key is not stored; playback steps 0..15 and wraps.
- PLAY with pattern 1,2: hold key 9 for 12 cycles → `note_o`=9, `gate_o`=1 throughout, `step_tick_o` still every 8 cycles. After release, `note_o` is the current pattern step.
- PLAY: `clear_i` together with `key_valid_i` → `len_o`=0, `gate_o`=0 next cycle, no step stored; `live_note` = the pressed key.
- Reset asserted mid-step in PLAY → every output at its reset value the following cycle; `state_o`=0.

Source files
------------

// File: rtl/note_sequencer.sv
// note_sequencer: keypad step sequencer and oscillator note arbiter.
// Records up to STEPS_P note indices in REC mode and plays them back at a
// fixed tempo in PLAY mode. A held live key overrides the pattern note.
// Ports:
//   clk_48kHz   - system/sample clock
//   rst_n       - synchronous active-low reset
//   mode_i      - 00 LIVE, 01 REC, 10 PLAY, 11 LIVE
//   key_valid_i - one-cycle pulse, key_code_i valid
//   key_code_i  - decoded key index
//   key_held_i  - level, any key pressed
//   clear_i     - one-cycle pulse, empties the pattern
//   note_o      - note index to the phase-increment LUT
//   gate_o      - oscillator enable
//   step_o      - current playback step
//   len_o       - recorded step count, 0..STEPS_P
//   full_o      - pattern full
//   step_tick_o - pulse at the start of each played step
//   state_o     - 0 LIVE, 1 REC, 2 PLAY
module note_sequencer #(
  parameter int unsigned STEPS_P     = 16,
  parameter int unsigned TEMPO_DIV_P = 12000,
  parameter int unsigned GATE_DIV_P  = 9000
) (
  input  logic       clk_48kHz,
  input  logic       rst_n,
  input  logic [1:0] mode_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       key_held_i,
  input  logic       clear_i,
  output logic [3:0] note_o,
  output logic       gate_o,
  output logic [3:0] step_o,
  output logic [4:0] len_o,
  output logic       full_o,
  output logic       step_tick_o,
  output logic [1:0] state_o
);

  localparam int unsigned CNT_W = (TEMPO_DIV_P > 1) ? $clog2(TEMPO_DIV_P) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TEMPO_DIV_P - 1);
  // One bit wider than cnt so GATE_DIV_P == TEMPO_DIV_P never matches.
  localparam logic [CNT_W:0]   GATE_CNT  = (CNT_W+1)'(GATE_DIV_P);
  localparam logic [4:0]       STEPS_LEN = 5'(STEPS_P);

  typedef enum logic [1:0] {
    ST_LIVE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  state_e           state, state_nxt;
  logic [3:0]       mem [STEPS_P];
  logic             mem_we;
  logic [3:0]       live_note, live_note_nxt;
  logic [4:0]       len_q, len_nxt;
  logic [3:0]       step_q, step_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W:0]   cnt_inc;
  logic [4:0]       step_inc;
  logic [3:0]       pat_note, pat_note_nxt;
  logic             pat_gate, pat_gate_nxt;
  logic [3:0]       note_nxt;
  logic             gate_nxt;
  logic             tick_nxt;
  logic             full_nxt;

  assign state_o = state;
  assign len_o   = len_q;
  assign step_o  = step_q;

  assign cnt_inc  = {1'b0, cnt} + (CNT_W+1)'(1);
  assign step_inc = {1'b0, step_q} + 5'd1;

  // State register
  always_ff @(posedge clk_48kHz) begin
    if (!rst_n) state <= ST_LIVE;
    else        state <= state_nxt;
  end

  // Next state, pattern datapath and output next values
  always_comb begin
    state_nxt     = ST_LIVE;
    live_note_nxt = key_valid_i ? key_code_i : live_note;
    len_nxt       = len_q;
    step_nxt      = step_q;
    cnt_nxt       = cnt;
    pat_note_nxt  = pat_note;
    pat_gate_nxt  = pat_gate;
    tick_nxt      = 1'b0;
    mem_we        = 1'b0;
    note_nxt      = live_note_nxt;
    gate_nxt      = key_held_i;

    case (mode_i)
      2'b01:   state_nxt = ST_REC;
      2'b10:   state_nxt = ST_PLAY;
      default: state_nxt = ST_LIVE;
    endcase

    // Recording; clear takes priority over a coincident key
    if (state == ST_REC && key_valid_i && !clear_i && len_q < STEPS_LEN) begin
      mem_we  = 1'b1;
      len_nxt = len_q + 5'd1;
    end
    if (clear_i) begin
      len_nxt  = '0;
      step_nxt = '0;
    end

    if (state_nxt == ST_PLAY) begin
      if (clear_i || len_q == 5'd0) begin
        // Empty pattern: silent, parked on step 0, note held
        step_nxt     = '0;
        cnt_nxt      = '0;
        pat_gate_nxt = 1'b0;
        if (state != ST_PLAY) pat_note_nxt = note_o;
      end else if (state != ST_PLAY) begin
        step_nxt     = '0;
        cnt_nxt      = '0;
        tick_nxt     = 1'b1;
        pat_note_nxt = mem[0];
        pat_gate_nxt = 1'b1;
      end else if (cnt == CNT_LAST) begin
        cnt_nxt      = '0;
        step_nxt     = (step_inc >= len_q) ? 4'd0 : step_inc[3:0];
        pat_note_nxt = mem[step_nxt];
        tick_nxt     = 1'b1;
        pat_gate_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_inc[CNT_W-1:0];
        if (cnt_inc == GATE_CNT) pat_gate_nxt = 1'b0;
      end
      // Live override; the pattern keeps running underneath
      note_nxt = key_held_i ? live_note_nxt : pat_note_nxt;
      gate_nxt = key_held_i | pat_gate_nxt;
    end else begin
      step_nxt     = '0;
      cnt_nxt      = '0;
      pat_gate_nxt = 1'b0;
    end

    full_nxt = (len_nxt == STEPS_LEN);
  end

  // Datapath and output registers
  always_ff @(posedge clk_48kHz) begin
    if (!rst_n) begin
      live_note   <= '0;
      len_q       <= '0;
      step_q      <= '0;
      cnt         <= '0;
      pat_note    <= '0;
      pat_gate    <= 1'b0;
      note_o      <= '0;
      gate_o      <= 1'b0;
      step_tick_o <= 1'b0;
      full_o      <= 1'b0;
    end else begin
      live_note   <= live_note_nxt;
      len_q       <= len_nxt;
      step_q      <= step_nxt;
      cnt         <= cnt_nxt;
      pat_note    <= pat_note_nxt;
      pat_gate    <= pat_gate_nxt;
      note_o      <= note_nxt;
      gate_o      <= gate_nxt;
      step_tick_o <= tick_nxt;
      full_o      <= full_nxt;
    end
  end

  // Pattern storage, deliberately not reset
  always_ff @(posedge clk_48kHz) begin
    if (rst_n && mem_we) mem[len_q[3:0]] <= key_code_i;
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with TEMPO_DIV_P=8, GATE_DIV_P=6.
module tb_note_sequencer;

  localparam int unsigned TEMPO = 8;
  localparam int unsigned GATE  = 6;

  logic       clk_48kHz = 1'b0;
  logic       rst_n;
  logic [1:0] mode_i;
  logic       key_valid_i;
  logic [3:0] key_code_i;
  logic       key_held_i;
  logic       clear_i;
  logic [3:0] note_o;
  logic       gate_o;
  logic [3:0] step_o;
  logic [4:0] len_o;
  logic       full_o;
  logic       step_tick_o;
  logic [1:0] state_o;

  note_sequencer #(
    .STEPS_P    (16),
    .TEMPO_DIV_P(TEMPO),
    .GATE_DIV_P (GATE)
  ) dut (
    .clk_48kHz  (clk_48kHz),
    .rst_n      (rst_n),
    .mode_i     (mode_i),
    .key_valid_i(key_valid_i),
    .key_code_i (key_code_i),
    .key_held_i (key_held_i),
    .clear_i    (clear_i),
    .note_o     (note_o),
    .gate_o     (gate_o),
    .step_o     (step_o),
    .len_o      (len_o),
    .full_o     (full_o),
    .step_tick_o(step_tick_o),
    .state_o    (state_o)
  );

  always #5 clk_48kHz = ~clk_48kHz;

  // care bits: 0 note, 1 gate, 2 step, 3 len, 4 full, 5 tick, 6 state
  typedef struct {
    int         tag;
    logic       rst;
    logic [1:0] mode;
    logic       kv;
    logic [3:0] kc;
    logic       held;
    logic       clr;
    logic [3:0] note;
    logic       gate;
    logic [3:0] step;
    logic [4:0] len;
    logic       full;
    logic       tick;
    logic [1:0] st;
    logic [6:0] care;
  } vec_t;

  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tag_ctr = 0;

  function automatic vec_t stim(input logic rst, input logic [1:0] mode, input logic kv,
                                input logic [3:0] kc, input logic held, input logic clr);
    vec_t v;
    v.tag = 0; v.rst = rst; v.mode = mode; v.kv = kv; v.kc = kc; v.held = held; v.clr = clr;
    v.note = '0; v.gate = 1'b0; v.step = '0; v.len = '0; v.full = 1'b0; v.tick = 1'b0;
    v.st = '0; v.care = '0;
    return v;
  endfunction

  // Attach expectations; a negative value means "don't care"
  function automatic vec_t ex(input vec_t vi, input int note, input int gate, input int step,
                              input int len, input int full, input int tick, input int st);
    vec_t v = vi;
    if (note >= 0) begin v.note = 4'(note); v.care[0] = 1'b1; end
    if (gate >= 0) begin v.gate = 1'(gate); v.care[1] = 1'b1; end
    if (step >= 0) begin v.step = 4'(step); v.care[2] = 1'b1; end
    if (len  >= 0) begin v.len  = 5'(len);  v.care[3] = 1'b1; end
    if (full >= 0) begin v.full = 1'(full); v.care[4] = 1'b1; end
    if (tick >= 0) begin v.tick = 1'(tick); v.care[5] = 1'b1; end
    if (st   >= 0) begin v.st   = 2'(st);   v.care[6] = 1'b1; end
    return v;
  endfunction

  task automatic chk(input int tag, input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(input vec_t v);
    vec_t e;
    v.tag = tag_ctr++;
    rst_n       = ~v.rst;
    mode_i      = v.mode;
    key_valid_i = v.kv;
    key_code_i  = v.kc;
    key_held_i  = v.held;
    clear_i     = v.clr;
    sb.push_back(v);
    @(posedge clk_48kHz);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (e.care[0]) chk(e.tag, "note",  8'(note_o),      8'(e.note));
      if (e.care[1]) chk(e.tag, "gate",  8'(gate_o),      8'(e.gate));
      if (e.care[2]) chk(e.tag, "step",  8'(step_o),      8'(e.step));
      if (e.care[3]) chk(e.tag, "len",   8'(len_o),       8'(e.len));
      if (e.care[4]) chk(e.tag, "full",  8'(full_o),      8'(e.full));
      if (e.care[5]) chk(e.tag, "tick",  8'(step_tick_o), 8'(e.tick));
      if (e.care[6]) chk(e.tag, "state", 8'(state_o),     8'(e.st));
    end
  endtask

  vec_t tbl [13];
  logic [3:0] pat3 [3];
  logic [3:0] pat2 [2];

  initial begin
    rst_n = 1'b0; mode_i = 2'b00; key_valid_i = 1'b0; key_code_i = '0;
    key_held_i = 1'b0; clear_i = 1'b0;

    // Reset, LIVE monitoring, then REC of 1,2,3
    tbl[0]  = ex(stim(1, 2'd0, 0, 4'd0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = ex(stim(0, 2'd0, 1, 4'd5, 1, 0), 5, 1, 0, 0, 0, 0, 0);
    tbl[2]  = ex(stim(0, 2'd0, 0, 4'd0, 1, 0), 5, 1, 0, 0, 0, 0, 0);
    tbl[3]  = ex(stim(0, 2'd0, 0, 4'd0, 0, 0), 5, 0, 0, 0, 0, 0, 0);
    tbl[4]  = ex(stim(0, 2'd0, 1, 4'd7, 0, 0), 7, 0, 0, 0, 0, 0, 0);
    tbl[5]  = ex(stim(0, 2'd3, 0, 4'd0, 0, 0), 7, 0, 0, 0, 0, 0, 0);
    tbl[6]  = ex(stim(0, 2'd1, 0, 4'd0, 0, 0), 7, 0, 0, 0, 0, 0, 1);
    tbl[7]  = ex(stim(0, 2'd1, 1, 4'd1, 0, 0), 1, 0, 0, 1, 0, 0, 1);
    tbl[8]  = ex(stim(0, 2'd1, 1, 4'd2, 0, 0), 2, 0, 0, 2, 0, 0, 1);
    tbl[9]  = ex(stim(0, 2'd1, 1, 4'd3, 1, 0), 3, 1, 0, 3, 0, 0, 1);
    tbl[10] = ex(stim(0, 2'd1, 0, 4'd0, 0, 0), 3, 0, 0, 3, 0, 0, 1);
    tbl[11] = ex(stim(0, 2'd1, 0, 4'd0, 1, 0), 3, 1, 0, 3, 0, 0, 1);
    tbl[12] = ex(stim(0, 2'd1, 0, 4'd0, 0, 0), 3, 0, 0, 3, 0, 0, 1);
    for (int i = 0; i < 13; i++) apply(tbl[i]);

    // Playback of 1,2,3 for 32 cycles
    pat3[0] = 4'd1; pat3[1] = 4'd2; pat3[2] = 4'd3;
    for (int k = 0; k < 32; k++)
      apply(ex(stim(0, 2'd2, 0, 4'd0, 0, 0), int'(pat3[(k / TEMPO) % 3]),
               ((k % TEMPO) < GATE) ? 1 : 0, (k / TEMPO) % 3, 3, 0,
               ((k % TEMPO) == 0) ? 1 : 0, 2));

    // Clear on the way to REC, record 1,2
    apply(ex(stim(0, 2'd1, 0, 4'd0, 0, 1), -1, 0, 0, 0, 0, 0, 1));
    apply(ex(stim(0, 2'd1, 1, 4'd1, 0, 0), 1, 0, 0, 1, 0, 0, 1));
    apply(ex(stim(0, 2'd1, 1, 4'd2, 0, 0), 2, 0, 0, 2, 0, 0, 1));

    // Playback with key 9 held for 12 cycles starting at cycle 2
    pat2[0] = 4'd1; pat2[1] = 4'd2;
    for (int k = 0; k < 24; k++) begin
      automatic bit held = (k >= 2) && (k < 14);
      automatic int note = held ? 9 : int'(pat2[(k / TEMPO) % 2]);
      automatic int gate = held ? 1 : (((k % TEMPO) < GATE) ? 1 : 0);
      apply(ex(stim(0, 2'd2, (k == 2), 4'd9, held, 0), note, gate, (k / TEMPO) % 2, 2, 0,
               ((k % TEMPO) == 0) ? 1 : 0, 2));
    end

    // Clear with a coincident key in PLAY: nothing stored, live note updated
    apply(ex(stim(0, 2'd2, 1, 4'd4, 0, 1), -1, 0, 0, 0, 0, 0, 2));
    apply(ex(stim(0, 2'd2, 0, 4'd0, 1, 0), 4, 1, 0, 0, 0, 0, 2));
    for (int k = 0; k < 10; k++)
      apply(ex(stim(0, 2'd2, 0, 4'd0, 0, 0), -1, 0, 0, 0, 0, 0, 2));

    // Fill the pattern; the 17th key is dropped
    apply(ex(stim(0, 2'd1, 0, 4'd0, 0, 0), -1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 17; i++) begin
      automatic int kc = (i < 16) ? ((i + 3) % 16) : 14;
      apply(ex(stim(0, 2'd1, 1, 4'(kc), 0, 0), kc, 0, 0, (i < 16) ? i + 1 : 16,
               (i >= 15) ? 1 : 0, 0, 1));
    end

    // Full playback through the wrap, then reset mid-step
    for (int k = 0; k < 132; k++)
      apply(ex(stim(0, 2'd2, 0, 4'd0, 0, 0), (((k / TEMPO) % 16) + 3) % 16,
               ((k % TEMPO) < GATE) ? 1 : 0, (k / TEMPO) % 16, 16, 1,
               ((k % TEMPO) == 0) ? 1 : 0, 2));
    apply(ex(stim(1, 2'd2, 0, 4'd0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
    apply(ex(stim(0, 2'd0, 0, 4'd0, 0, 0), 0, 0, 0, 0, 0, 0, 0));

    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
